// File: rtl/dsp_wresp_router.sv
// dsp_wresp_router
// Write-response router for one master port of the AXI4 interconnect dispatcher.
// B responses go back to the master in the order the AW dispatcher issued the
// write addresses. Each slave has its own response FIFO. Writes that decoded to
// no slave get a DECERR response generated locally, once the W dispatcher has
// sunk their last beat.
//
// Optional feature macro: DSP_WRESP_OUT_REG_EN
//   defined   -> the master B channel is driven from a one-entry output register
//                (one extra cycle of latency, full throughput kept)
//   undefined -> the master B channel is driven combinationally from the heads
module dsp_wresp_router #(
   parameter int SLV_AMT         = 4,
   parameter int OUTSTANDING_AMT = 8,
   parameter int TRANS_MST_ID_W  = 5,
   parameter int TRANS_WR_RESP_W = 2,
   parameter int SLV_ID_W        = $clog2(SLV_AMT),
   parameter logic [TRANS_WR_RESP_W-1:0] DECERR_RESP = 2'b11
) (
   input  logic                                  ACLK_i,
   input  logic                                  ARESET_i,
   input  logic                                  dsp_AW_shift_en_i,
   input  logic [SLV_ID_W-1:0]                   dsp_AW_slv_id_i,
   input  logic [TRANS_MST_ID_W-1:0]             dsp_AW_id_i,
   input  logic                                  dsp_AW_decerr_i,
   output logic                                  dsp_AW_ready_o,
   input  logic                                  dsp_W_decerr_last_i,
   output logic [$clog2(OUTSTANDING_AMT+1)-1:0]  dsp_outst_cnt_o,
   input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]     sa_BID_i,
   input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]    sa_BRESP_i,
   input  logic [SLV_AMT-1:0]                    sa_BVALID_i,
   output logic [SLV_AMT-1:0]                    sa_BREADY_o,
   input  logic                                  m_BREADY_i,
   output logic [TRANS_MST_ID_W-1:0]             m_BID_o,
   output logic [TRANS_WR_RESP_W-1:0]            m_BRESP_o,
   output logic                                  m_BVALID_o
);

   localparam int PTR_W = $clog2(OUTSTANDING_AMT);
   localparam int CNT_W = $clog2(OUTSTANDING_AMT+1);
   localparam int ORD_W = 1 + TRANS_MST_ID_W + SLV_ID_W;
   localparam int RSP_W = TRANS_MST_ID_W + TRANS_WR_RESP_W;
   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(OUTSTANDING_AMT);

   // order FIFO: {decerr, awid, slv_id}
   logic [ORD_W-1:0]          ord_mem [OUTSTANDING_AMT];
   logic [PTR_W:0]            ord_wr_ptr;
   logic [PTR_W:0]            ord_rd_ptr;
   logic                      ord_empty;
   logic                      ord_full;
   logic                      ord_push;
   logic                      ord_pop;
   logic [ORD_W-1:0]          ord_head;
   logic                      head_decerr;
   logic [TRANS_MST_ID_W-1:0] head_id;
   logic [SLV_ID_W-1:0]       head_slv;

   // per-slave response FIFOs: {BID, BRESP}
   logic [RSP_W-1:0]          rsp_mem [SLV_AMT][OUTSTANDING_AMT];
   logic [PTR_W:0]            rsp_wr_ptr [SLV_AMT];
   logic [PTR_W:0]            rsp_rd_ptr [SLV_AMT];
   logic [SLV_AMT-1:0]        rsp_empty;
   logic [SLV_AMT-1:0]        rsp_full;
   logic [SLV_AMT-1:0]        rsp_push;
   logic [SLV_AMT-1:0]        rsp_pop;
   logic [RSP_W-1:0]          rsp_head;

   // head candidate and delivery control
   logic                       cand_valid;
   logic [TRANS_MST_ID_W-1:0]  cand_bid;
   logic [TRANS_WR_RESP_W-1:0] cand_bresp;
   logic                       take;
   logic                       m_hs;

   // decerr credits and outstanding count
   logic [CNT_W-1:0]          credit_cnt;
   logic                      credit_inc;
   logic                      credit_dec;

   assign ord_empty      = (ord_wr_ptr == ord_rd_ptr);
   assign ord_full       = (ord_wr_ptr[PTR_W] != ord_rd_ptr[PTR_W]) &&
                           (ord_wr_ptr[PTR_W-1:0] == ord_rd_ptr[PTR_W-1:0]);
   assign ord_push       = dsp_AW_shift_en_i & ~ord_full;
   assign ord_pop        = take;
   assign dsp_AW_ready_o = ~ord_full;
   assign sa_BREADY_o    = ~rsp_full;
   assign m_hs           = m_BVALID_o & m_BREADY_i;
   assign credit_inc     = dsp_W_decerr_last_i;
   assign credit_dec     = take & head_decerr;

   // order FIFO storage; entries are only meaningful between the pointers, so no reset
   always_ff @(posedge ACLK_i) begin
      if (ord_push) begin
         ord_mem[ord_wr_ptr[PTR_W-1:0]] <= {dsp_AW_decerr_i, dsp_AW_id_i, dsp_AW_slv_id_i};
      end
   end

   // order FIFO pointers; a push into a full FIFO is simply not taken
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         ord_wr_ptr <= '0;
         ord_rd_ptr <= '0;
      end else begin
         if (ord_push) begin
            ord_wr_ptr <= ord_wr_ptr + 1'b1;
         end
         if (ord_pop) begin
            ord_rd_ptr <= ord_rd_ptr + 1'b1;
         end
      end
   end

   // response FIFO status and accepted slave handshakes
   always_comb begin
      rsp_empty = '0;
      rsp_full  = '0;
      rsp_push  = '0;
      for (int i = 0; i < SLV_AMT; i++) begin
         rsp_empty[i] = (rsp_wr_ptr[i] == rsp_rd_ptr[i]);
         rsp_full[i]  = (rsp_wr_ptr[i][PTR_W] != rsp_rd_ptr[i][PTR_W]) &&
                        (rsp_wr_ptr[i][PTR_W-1:0] == rsp_rd_ptr[i][PTR_W-1:0]);
         rsp_push[i]  = sa_BVALID_i[i] & ~rsp_full[i];
      end
   end

   // response FIFO storage, one slice of BID/BRESP per slave
   always_ff @(posedge ACLK_i) begin
      for (int i = 0; i < SLV_AMT; i++) begin
         if (rsp_push[i]) begin
            rsp_mem[i][rsp_wr_ptr[i][PTR_W-1:0]] <=
               {sa_BID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W],
                sa_BRESP_i[i*TRANS_WR_RESP_W +: TRANS_WR_RESP_W]};
         end
      end
   end

   // response FIFO pointers
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         for (int i = 0; i < SLV_AMT; i++) begin
            rsp_wr_ptr[i] <= '0;
            rsp_rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SLV_AMT; i++) begin
            if (rsp_push[i]) begin
               rsp_wr_ptr[i] <= rsp_wr_ptr[i] + 1'b1;
            end
            if (rsp_pop[i]) begin
               rsp_rd_ptr[i] <= rsp_rd_ptr[i] + 1'b1;
            end
         end
      end
   end

   // head candidate: only the order head may be delivered, nothing overtakes it
   always_comb begin
      ord_head    = ord_mem[ord_rd_ptr[PTR_W-1:0]];
      head_decerr = ord_head[ORD_W-1];
      head_id     = ord_head[SLV_ID_W +: TRANS_MST_ID_W];
      head_slv    = ord_head[SLV_ID_W-1:0];
      rsp_head    = rsp_mem[head_slv][rsp_rd_ptr[head_slv][PTR_W-1:0]];
      cand_valid  = 1'b0;
      cand_bid    = '0;
      cand_bresp  = '0;
      if (!ord_empty) begin
         if (head_decerr) begin
            cand_valid = (credit_cnt != '0);
         end else begin
            cand_valid = ~rsp_empty[head_slv];
         end
      end
      if (cand_valid) begin
         if (head_decerr) begin
            cand_bid   = head_id;
            cand_bresp = DECERR_RESP;
         end else begin
            {cand_bid, cand_bresp} = rsp_head;
         end
      end
   end

   // the slave FIFO at the head is popped together with a non-decerr order entry
   always_comb begin
      rsp_pop = '0;
      if (take && !head_decerr) begin
         rsp_pop[head_slv] = 1'b1;
      end
   end

   // decerr credits: one per sunk WLAST of a decode-error burst, saturating both ways
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         credit_cnt <= '0;
      end else if (credit_inc && !credit_dec) begin
         if (credit_cnt != CREDIT_MAX) begin
            credit_cnt <= credit_cnt + 1'b1;
         end
      end else if (credit_dec && !credit_inc) begin
         if (credit_cnt != '0) begin
            credit_cnt <= credit_cnt - 1'b1;
         end
      end
   end

   // outstanding writes: issued but not yet handed to the master
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         dsp_outst_cnt_o <= '0;
      end else if (ord_push && !m_hs) begin
         dsp_outst_cnt_o <= dsp_outst_cnt_o + 1'b1;
      end else if (m_hs && !ord_push) begin
         if (dsp_outst_cnt_o != '0) begin
            dsp_outst_cnt_o <= dsp_outst_cnt_o - 1'b1;
         end
      end
   end

`ifdef DSP_WRESP_OUT_REG_EN
   logic                       out_valid;
   logic [TRANS_MST_ID_W-1:0]  out_bid;
   logic [TRANS_WR_RESP_W-1:0] out_bresp;

   // the head leaves its FIFOs when it moves into the output register
   assign take = cand_valid & (~out_valid | m_BREADY_i);

   // one-entry output register, reloaded in the same cycle it drains
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         out_valid <= 1'b0;
         out_bid   <= '0;
         out_bresp <= '0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_bid   <= cand_bid;
         out_bresp <= cand_bresp;
      end else if (m_BREADY_i) begin
         out_valid <= 1'b0;
      end
   end

   assign m_BVALID_o = out_valid;
   assign m_BID_o    = out_bid;
   assign m_BRESP_o  = out_bresp;
`else
   // the head leaves its FIFOs on the master handshake itself
   assign take       = cand_valid & m_BREADY_i;
   assign m_BVALID_o = cand_valid;
   assign m_BID_o    = cand_bid;
   assign m_BRESP_o  = cand_bresp;
`endif

endmodule

// File: tb/tb_dsp_wresp_router.sv
// tb_dsp_wresp_router
// Directed bench for dsp_wresp_router with a response scoreboard. Expected
// master responses are queued when the write address is issued; a monitor
// compares every master B handshake against the queue head.
// Honours DSP_WRESP_OUT_REG_EN for the extra output-register latency.
`timescale 1ns/1ps
module tb_dsp_wresp_router;

`ifdef DSP_WRESP_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct packed {
      logic [4:0] bid;
      logic [1:0] bresp;
   } exp_t;

   logic        ACLK_i = 1'b0;
   logic        ARESET_i = 1'b1;
   logic        dsp_AW_shift_en_i = 1'b0;
   logic [1:0]  dsp_AW_slv_id_i = '0;
   logic [4:0]  dsp_AW_id_i = '0;
   logic        dsp_AW_decerr_i = 1'b0;
   logic        dsp_AW_ready_o;
   logic        dsp_W_decerr_last_i = 1'b0;
   logic [3:0]  dsp_outst_cnt_o;
   logic [19:0] sa_BID_i = '0;
   logic [7:0]  sa_BRESP_i = '0;
   logic [3:0]  sa_BVALID_i = '0;
   logic [3:0]  sa_BREADY_o;
   logic        m_BREADY_i = 1'b0;
   logic [4:0]  m_BID_o;
   logic [1:0]  m_BRESP_o;
   logic        m_BVALID_o;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   dsp_wresp_router dut (
      .ACLK_i              (ACLK_i),
      .ARESET_i            (ARESET_i),
      .dsp_AW_shift_en_i   (dsp_AW_shift_en_i),
      .dsp_AW_slv_id_i     (dsp_AW_slv_id_i),
      .dsp_AW_id_i         (dsp_AW_id_i),
      .dsp_AW_decerr_i     (dsp_AW_decerr_i),
      .dsp_AW_ready_o      (dsp_AW_ready_o),
      .dsp_W_decerr_last_i (dsp_W_decerr_last_i),
      .dsp_outst_cnt_o     (dsp_outst_cnt_o),
      .sa_BID_i            (sa_BID_i),
      .sa_BRESP_i          (sa_BRESP_i),
      .sa_BVALID_i         (sa_BVALID_i),
      .sa_BREADY_o         (sa_BREADY_o),
      .m_BREADY_i          (m_BREADY_i),
      .m_BID_o             (m_BID_o),
      .m_BRESP_o           (m_BRESP_o),
      .m_BVALID_o          (m_BVALID_o)
   );

   // free-running 100 MHz clock
   always #5 ACLK_i = ~ACLK_i;

   task automatic tick();
      @(posedge ACLK_i);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic expectResp(input logic [4:0] id, input logic [1:0] resp);
      exp_t e;
      e.bid   = id;
      e.bresp = resp;
      sb.push_back(e);
   endtask

   // issue one write address for a single cycle
   task automatic applyStimulus(input logic [1:0] slv, input logic [4:0] id, input logic decerr);
      dsp_AW_shift_en_i = 1'b1;
      dsp_AW_slv_id_i   = slv;
      dsp_AW_id_i       = id;
      dsp_AW_decerr_i   = decerr;
      tick();
      dsp_AW_shift_en_i = 1'b0;
      dsp_AW_decerr_i   = 1'b0;
   endtask

   task automatic sendResp(input int slv, input logic [4:0] id, input logic [1:0] resp);
      sa_BID_i[slv*5 +: 5]   = id;
      sa_BRESP_i[slv*2 +: 2] = resp;
      sa_BVALID_i[slv]       = 1'b1;
      tick();
      sa_BVALID_i[slv]       = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
      end
   endtask

   // scoreboard monitor: every master handshake must match the oldest expectation
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge ACLK_i);
         if (!ARESET_i && m_BVALID_o && m_BREADY_i) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_resp: got id=%0d resp=%0d, required no response (t=%0t)",
                        m_BID_o, m_BRESP_o, $time);
            end else begin
               e = sb.pop_front();
               if (m_BID_o !== e.bid || m_BRESP_o !== e.bresp) begin
                  errors++;
                  $display("[TB] FAIL b_resp: got id=%0d resp=%0d, required id=%0d resp=%0d (t=%0t)",
                           m_BID_o, m_BRESP_o, e.bid, e.bresp, $time);
               end
            end
         end
      end
   end

   // safety net so the run always ends
   initial begin : watchdog
      #200000;
      errors++;
      $display("[TB] FAIL timeout: simulation exceeded its time budget");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : stimulus
      $display("[TB] start, output latency %0d", LAT);

      // reset and idle
      waitCycles(3);
      ARESET_i = 1'b0;
      tick();
      @(negedge ACLK_i);
      checkOutput("rst_sa_bready", 32'(sa_BREADY_o), 32'hF);
      checkOutput("rst_aw_ready", 32'(dsp_AW_ready_o), 32'h1);
      checkOutput("rst_bvalid", 32'(m_BVALID_o), 32'h0);
      checkOutput("rst_cnt", 32'(dsp_outst_cnt_o), 32'h0);
      tick();

      // reordering: slave 0 answers first but slave 2 was issued first
      $display("[TB] reorder");
      m_BREADY_i = 1'b1;
      expectResp(5'd3, 2'b10);
      applyStimulus(2'd2, 5'd3, 1'b0);
      expectResp(5'd7, 2'b00);
      applyStimulus(2'd0, 5'd7, 1'b0);
      @(negedge ACLK_i);
      checkOutput("reorder_cnt2", 32'(dsp_outst_cnt_o), 32'd2);
      tick();
      sendResp(0, 5'd7, 2'b00);
      waitCycles(2);
      @(negedge ACLK_i);
      checkOutput("reorder_blocked", 32'(m_BVALID_o), 32'h0);
      tick();
      sendResp(2, 5'd3, 2'b10);
      waitCycles(4);
      @(negedge ACLK_i);
      checkOutput("reorder_cnt0", 32'(dsp_outst_cnt_o), 32'd0);
      tick();

      // decode error waits for its credit
      $display("[TB] decerr");
      expectResp(5'd5, 2'b11);
      applyStimulus(2'd1, 5'd5, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK_i);
         checkOutput("decerr_wait", 32'(m_BVALID_o), 32'h0);
         tick();
      end
      dsp_W_decerr_last_i = 1'b1;
      tick();
      dsp_W_decerr_last_i = 1'b0;
      waitCycles(3);
      @(negedge ACLK_i);
      checkOutput("decerr_cnt0", 32'(dsp_outst_cnt_o), 32'd0);
      tick();
      // the credit was consumed: a second decerr must wait again
      expectResp(5'd6, 2'b11);
      applyStimulus(2'd0, 5'd6, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK_i);
         checkOutput("decerr_credit_used", 32'(m_BVALID_o), 32'h0);
         tick();
      end
      dsp_W_decerr_last_i = 1'b1;
      tick();
      dsp_W_decerr_last_i = 1'b0;
      waitCycles(3);

      // stall: output held stable, plus the latency check
      $display("[TB] stall");
      m_BREADY_i = 1'b0;
      expectResp(5'd9, 2'b01);
      applyStimulus(2'd3, 5'd9, 1'b0);
      sendResp(3, 5'd9, 2'b01);
      @(negedge ACLK_i);
      checkOutput("latency_first", 32'(m_BVALID_o), (LAT == 1) ? 32'h1 : 32'h0);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK_i);
         checkOutput("stall_bvalid", 32'(m_BVALID_o), 32'h1);
         checkOutput("stall_bid", 32'(m_BID_o), 32'd9);
         checkOutput("stall_bresp", 32'(m_BRESP_o), 32'd1);
         tick();
      end
      // AW push and master pop in the same cycle
      expectResp(5'd4, 2'b00);
      m_BREADY_i = 1'b1;
      applyStimulus(2'd3, 5'd4, 1'b0);
      @(negedge ACLK_i);
      checkOutput("push_pop_cnt", 32'(dsp_outst_cnt_o), 32'd1);
      tick();
      sendResp(3, 5'd4, 2'b00);
      waitCycles(4);
      @(negedge ACLK_i);
      checkOutput("stall_cnt0", 32'(dsp_outst_cnt_o), 32'd0);
      tick();

      // backpressure: fill the order FIFO and slave 1's response FIFO
      $display("[TB] backpressure");
      m_BREADY_i = 1'b0;
      dsp_AW_shift_en_i = 1'b1;
      dsp_AW_slv_id_i   = 2'd1;
      for (int i = 0; i < 8; i++) begin
         dsp_AW_id_i = 5'(i + 10);
         expectResp(5'(i + 10), 2'(i));
         tick();
      end
      dsp_AW_shift_en_i = 1'b0;
      @(negedge ACLK_i);
      checkOutput("full_aw_ready", 32'(dsp_AW_ready_o), 32'h0);
      checkOutput("full_cnt", 32'(dsp_outst_cnt_o), 32'd8);
      tick();
      applyStimulus(2'd1, 5'd31, 1'b0);
      @(negedge ACLK_i);
      checkOutput("dropped_cnt", 32'(dsp_outst_cnt_o), 32'd8);
      checkOutput("dropped_aw_ready", 32'(dsp_AW_ready_o), 32'h0);
      tick();
      sa_BVALID_i[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sa_BID_i[5 +: 5]   = 5'(i + 10);
         sa_BRESP_i[2 +: 2] = 2'(i);
         tick();
      end
      sa_BVALID_i[1] = 1'b0;
      @(negedge ACLK_i);
      checkOutput("slv1_bready", 32'(sa_BREADY_o[1]), (LAT == 1) ? 32'h0 : 32'h1);
      checkOutput("full_bvalid", 32'(m_BVALID_o), 32'h1);
      tick();
      m_BREADY_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge ACLK_i);
         checkOutput("drain_back_to_back", 32'(m_BVALID_o), 32'h1);
         tick();
      end
      @(negedge ACLK_i);
      checkOutput("drain_done_bvalid", 32'(m_BVALID_o), 32'h0);
      checkOutput("drain_cnt0", 32'(dsp_outst_cnt_o), 32'd0);
      tick();

      // reset with queued entries and a response on display
      $display("[TB] reset mid-operation");
      m_BREADY_i = 1'b0;
      applyStimulus(2'd0, 5'd1, 1'b0);
      applyStimulus(2'd0, 5'd2, 1'b0);
      applyStimulus(2'd0, 5'd3, 1'b0);
      sendResp(0, 5'd1, 2'b00);
      tick();
      @(negedge ACLK_i);
      checkOutput("pre_rst_bvalid", 32'(m_BVALID_o), 32'h1);
      checkOutput("pre_rst_cnt", 32'(dsp_outst_cnt_o), 32'd3);
      tick();
      ARESET_i = 1'b1;
      #1;
      checkOutput("mid_rst_bvalid", 32'(m_BVALID_o), 32'h0);
      checkOutput("mid_rst_bid", 32'(m_BID_o), 32'h0);
      checkOutput("mid_rst_bresp", 32'(m_BRESP_o), 32'h0);
      checkOutput("mid_rst_cnt", 32'(dsp_outst_cnt_o), 32'h0);
      checkOutput("mid_rst_aw_ready", 32'(dsp_AW_ready_o), 32'h1);
      checkOutput("mid_rst_sa_bready", 32'(sa_BREADY_o), 32'hF);
      tick();
      ARESET_i = 1'b0;
      m_BREADY_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK_i);
         checkOutput("post_rst_no_stale", 32'(m_BVALID_o), 32'h0);
         tick();
      end

      waitCycles(2);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dsp_wresp_router.md
# dsp_wresp_router

Write-response router for the AXI4 interconnect dispatcher, one instance per master port. It returns B responses to the master in the order the AW dispatcher issued the write addresses, taking them from per-slave response FIFOs. It also generates DECERR responses locally for writes decoded to no slave, and gives the AW dispatcher backpressure and an outstanding-write count.

## Interface
Parameters:
- SLV_AMT, 4: number of slave arbitration ports.
- OUTSTANDING_AMT, 8: depth of the order FIFO and of each per-slave response FIFO; must be a power of two, at least 2.
- TRANS_MST_ID_W, 5: BID/AWID width.
- TRANS_WR_RESP_W, 2: BRESP width.
- SLV_ID_W, $clog2(SLV_AMT): slave index width.
- DECERR_RESP, 2'b11: BRESP value driven for decode-error writes.

Ports (one clock; reset is asynchronous and active-high):
- ACLK_i  in  1  clock; all logic is rising-edge.
- ARESET_i  in  1  asynchronous active-high reset.
- dsp_AW_shift_en_i  in  1  the AW dispatcher issued one write address this cycle.
- dsp_AW_slv_id_i  in  SLV_ID_W  target slave of the issued write.
- dsp_AW_id_i  in  TRANS_MST_ID_W  AWID of the issued write.
- dsp_AW_decerr_i  in  1  the issued write decoded to no slave.
- dsp_AW_ready_o  out  1  order FIFO not full; the AW dispatcher may shift.
- dsp_W_decerr_last_i  in  1  the W dispatcher has sunk the WLAST beat of a decode-error burst.
- dsp_outst_cnt_o  out  $clog2(OUTSTANDING_AMT+1)  number of writes issued but not yet answered to the master.
- sa_BID_i  in  TRANS_MST_ID_W*SLV_AMT  per-slave BID, slave i at slice i.
- sa_BRESP_i  in  TRANS_WR_RESP_W*SLV_AMT  per-slave BRESP.
- sa_BVALID_i  in  SLV_AMT  per-slave BVALID.
- sa_BREADY_o  out  SLV_AMT  per-slave BREADY; bit i = response FIFO i not full.
- m_BREADY_i  in  1  master BREADY.
- m_BID_o  out  TRANS_MST_ID_W  master BID.
- m_BRESP_o  out  TRANS_WR_RESP_W  master BRESP.
- m_BVALID_o  out  1  master BVALID.

## Operation
- **Order FIFO.** Each entry is {decerr, awid, slv_id}. It is pushed on dsp_AW_shift_en_i and popped when the master B handshake completes.
- **Full order FIFO.** A push while the FIFO is full is dropped: no state changes, and the count is not incremented. A push and a pop in the same cycle both take effect.
- **Response FIFOs.** There is one per slave, each entry {BID, BRESP}.
  - A push happens on sa_BVALID_i[i] & sa_BREADY_o[i].
  - A pop happens only when the order head is a non-decerr entry with slv_id == i and the master handshake completes.
- **Decerr credit counter.** Width $clog2(OUTSTANDING_AMT+1).
  - It increments on dsp_W_decerr_last_i.
  - It decrements when a decerr head is delivered.
  - Increment and decrement in the same cycle leave it unchanged.
  - It saturates at both ends.
- **Head-candidate valid.** The head is ready to deliver when the order FIFO is not empty, and:
  - for a decerr head, the credit counter is above 0; or
  - for a non-decerr head, response FIFO[slv_id] is not empty.
- **Delivered data.**
  - Decerr head: BID = stored awid, BRESP = DECERR_RESP.
  - Otherwise: the head of FIFO[slv_id].
- **No head-of-line bypass.** Responses that are waiting behind a stalled head stay queued.
- **Outstanding count.** dsp_outst_cnt_o is +1 on an accepted push and −1 on a master handshake; both in the same cycle leave it unchanged.
- **Reset values (asynchronous).**
  - All FIFOs, the credit counter and dsp_outst_cnt_o are 0.
  - m_BVALID_o, m_BID_o and m_BRESP_o are 0.
  - sa_BREADY_o is all ones and dsp_AW_ready_o is 1.
- **Reset mid-operation.** Asserting ARESET_i discards every queued entry and any response being presented; m_BVALID_o falls immediately.

## Timing
- Slave response accepted at edge N: the candidate is valid from cycle N+1 (FIFO write latency 1), provided the entry is already at the order head.
- AW shift at edge N: the order entry is visible at the head from N+1, and dsp_AW_ready_o/dsp_outst_cnt_o update from N+1.
- dsp_W_decerr_last_i at edge N: the credit is usable from N+1.
- While m_BVALID_o is high and m_BREADY_i is low, m_BID_o and m_BRESP_o stay stable.
- Throughput: one response per cycle.

## Configuration
- **DSP_WRESP_OUT_REG_EN defined:** m_BVALID_o, m_BID_o and m_BRESP_o come from a one-entry output register.
  - The register loads when it is empty or being drained, so full throughput is kept.
  - This adds 1 cycle of latency: a slave response at edge N appears at the master from N+2.
  - The FIFO pops when the register loads; dsp_outst_cnt_o still decrements on the master handshake.
- **Undefined:** the outputs are a combinational function of the FIFO heads; there is no output-path register.

## Test plan
- Reset, then idle: sa_BREADY_o=all ones, dsp_AW_ready_o=1, m_BVALID_o=0, dsp_outst_cnt_o=0.
- Reordering: AW to slave 2 (id 3), then slave 0 (id 7); slave 0 returns OKAY first, then slave 2 returns SLVERR. Master receives (id 3, 2'b10) first, then (id 7, 2'b00).
- Decode error: AW with decerr=1, id 5; hold dsp_W_decerr_last_i low for 10 cycles, so m_BVALID_o stays 0; pulse it once. Master receives (5, 2'b11) and the credit counter returns to 0.
- Backpressure: 8 AW shifts with no responses; dsp_AW_ready_o=0 and cnt=8; a 9th shift is ignored. Slave 1 fills its FIFO with 8 responses, then sa_BREADY_o[1]=0. With m_BREADY_i=1, 8 responses drain in 8 consecutive cycles and cnt=0.
- Stall: m_BREADY_i low for 5 cycles while m_BVALID_o=1; BID/BRESP stable. Simultaneous AW push and master pop leave cnt unchanged.
- ARESET_i asserted with 3 queued entries; all outputs return to reset values immediately, and no stale response appears afterwards.
- Repeat each scenario with DSP_WRESP_OUT_REG_EN defined and check the +1 latency.
